// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (16-bit little-endian word count, then
// the data bytes), packs every four bytes into a little-endian 32-bit word and
// writes the words to instruction memory from byte address 0 upwards. The core
// is held in reset (cpu_rst=1) until the image has been loaded.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  load_start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0]      imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** (ADDR_WIDTH - 2));

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                state_q;
    logic [15:0]           count_q;
    logic [15:0]           idx_q;
    logic [1:0]            lane_q;
    logic [23:0]           shift_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [WIDTH-1:0]      imem_wdata_q;
    logic                  cpu_rst_q;
    logic                  load_done_q;
    logic                  load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic                  accept_s;
    logic                  in_range_s;
    logic [16:0]           idx_d;
    logic [31:0]           word_s;

    // The loader is receptive in every state except the two terminal ones.
    assign byte_ready = (state_q != S_DONE) && (state_q != S_ERROR);
    assign accept_s   = byte_valid && byte_ready;
    assign idx_d      = {1'b0, idx_q} + 17'd1;
    assign in_range_s = ({1'b0, idx_q} < MAX_WORDS);
    assign word_s     = {byte_data, shift_q};

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

    // Loader FSM: header capture, word assembly, memory writes and core release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_HDR0;
            count_q      <= 16'd0;
            idx_q        <= 16'd0;
            lane_q       <= 2'd0;
            shift_q      <= 24'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            // Write strobe is a one-cycle pulse unless a word completes below.
            imem_we_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept_s && (state_q == S_HDR0 || state_q == S_HDR1 || state_q == S_DATA)) begin
                csum_q <= csum_q ^ byte_data;
            end
`endif
            case (state_q)
                S_HDR0: begin
                    if (accept_s) begin
                        count_q[7:0] <= byte_data;
                        state_q      <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept_s) begin
                        count_q[15:8] <= byte_data;
                        if ({byte_data, count_q[7:0]} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q     <= S_CSUM;
`else
                            state_q     <= S_DONE;
                            cpu_rst_q   <= 1'b0;
                            load_done_q <= 1'b1;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            idx_q <= idx_d[15:0];
                            if (in_range_s) begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= {idx_q[ADDR_WIDTH-3:0], 2'b00};
                                imem_wdata_q <= word_s;
                            end else begin
                                // Beyond capacity: consume the word, keep the address.
                                load_err_q <= 1'b1;
                            end
                            if (idx_d == {1'b0, count_q}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q <= S_CSUM;
`else
                                if (load_err_q || !in_range_s) begin
                                    state_q <= S_ERROR;
                                end else begin
                                    state_q     <= S_DONE;
                                    cpu_rst_q   <= 1'b0;
                                    load_done_q <= 1'b1;
                                end
`endif
                            end
                        end else begin
                            case (lane_q)
                                2'd0:    shift_q[7:0]   <= byte_data;
                                2'd1:    shift_q[15:8]  <= byte_data;
                                2'd2:    shift_q[23:16] <= byte_data;
                                default: shift_q        <= shift_q;
                            endcase
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept_s) begin
                        // An overflow error outranks the checksum result.
                        if (load_err_q) begin
                            state_q <= S_ERROR;
                        end else if (byte_data == csum_q) begin
                            state_q     <= S_DONE;
                            cpu_rst_q   <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERROR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    if (load_start) begin
                        state_q     <= S_HDR0;
                        count_q     <= 16'd0;
                        idx_q       <= 16'd0;
                        lane_q      <= 2'd0;
                        cpu_rst_q   <= 1'b1;
                        load_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q      <= 8'd0;
`endif
                    end
                end
                default: begin
                    // Unreachable encoding: recover into a fresh load with the core held.
                    state_q     <= S_HDR0;
                    idx_q       <= 16'd0;
                    lane_q      <= 2'd0;
                    cpu_rst_q   <= 1'b1;
                    load_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (ADDR_WIDTH=4, so capacity is 4 words).
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_start;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    int n_cmp  = 0;
    int n_fail = 0;

    imem_loader #(.WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .load_start (load_start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log: address, data and cycles since the most recent byte accept.
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          wr_cnt  = 0;
    logic [3:0]  wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    int          wr_lat  [0:31];

    always @(posedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] <= imem_addr;
                wr_data[wr_cnt] <= imem_wdata;
                wr_lat[wr_cnt]  <= cyc - acc_cyc;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (byte_valid && byte_ready) acc_cyc <= cyc;
        cyc <= cyc + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_send: got %b need 1 (byte %h)", byte_ready, b);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic crst,
                                input logic done, input logic err);
        n_cmp++;
        if ({byte_ready, cpu_rst, load_done, load_err} !== {rdy, crst, done, err}) begin
            n_fail++;
            $display("FAIL %s: ready/cpu_rst/done/err got %b%b%b%b need %b%b%b%b", tag,
                     byte_ready, cpu_rst, load_done, load_err, rdy, crst, done, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(2);
        n_cmp++;
        if ({byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err}
            !== {1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b",
                     byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err);
        end
        rst = 1'b1;
        // Partial stream: header plus three bytes of the first word, then reset.
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0);
        check_status("midstream_busy", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_status("async_reset", 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_we: got %b need 0", imem_we);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        n_cmp++;
        if (wr_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_no_partial_write: got %0d writes need 0", wr_cnt);
        end
    endtask

    task automatic check_two_word(input string tag, input int base);
        n_cmp++;
        if (wr_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes need 2", tag, wr_cnt - base);
        end else begin
            n_cmp++;
            if (wr_addr[base] !== 4'h0 || wr_data[base] !== 32'h00A00513 || wr_lat[base] !== 1) begin
                n_fail++;
                $display("FAIL %s_w0: got %h@%h lat %0d need 00a00513@0 lat 1",
                         tag, wr_data[base], wr_addr[base], wr_lat[base]);
            end
            n_cmp++;
            if (wr_addr[base+1] !== 4'h4 || wr_data[base+1] !== 32'h00100593 || wr_lat[base+1] !== 1) begin
                n_fail++;
                $display("FAIL %s_w1: got %h@%h lat %0d need 00100593@4 lat 1",
                         tag, wr_data[base+1], wr_addr[base+1], wr_lat[base+1]);
            end
        end
    endtask

    task automatic test_two_word();
        logic [7:0] img [0:9];
        int base;
        img  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        base = wr_cnt;
        for (int i = 0; i < 10; i++) send_byte(img[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h32);
`endif
        check_status("two_word_done", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check_two_word("two_word", base);
    endtask

    task automatic test_restart_from_done();
        pulse_start();
        check_status("restart_from_done", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        int base;
        base = wr_cnt;
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_status("empty_csum_wait", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h00);
`endif
        check_status("empty_done", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (wr_cnt !== base) begin
            n_fail++;
            $display("FAIL empty_no_write: got %0d writes need 0", wr_cnt - base);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] img [0:9];
        int base;
        img  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        base = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i]);
            if (i == 4) begin
                // load_start during DATA must be ignored.
                pulse_start();
                check_status("gaps_busy", 1'b1, 1'b1, 1'b0, 1'b0);
            end else begin
                idle(1);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h32);
`endif
        check_status("gaps_done", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check_two_word("gaps", base);
    endtask

    task automatic test_overflow();
        int         base;
        logic [7:0] b;
        logic [7:0] csum;
        base = wr_cnt;
        csum = 8'h05;
        send_byte(8'h05);
        send_byte(8'h00);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                b    = 8'(16 * k + j);
                csum = csum ^ b;
                send_byte(b);
            end
            if (k == 3) begin
                check_status("overflow_before_discard", 1'b1, 1'b1, 1'b0, 1'b0);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Correct checksum: the overflow must still win.
        send_byte(csum);
`endif
        check_status("overflow_error", 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        n_cmp++;
        if (wr_cnt - base !== 4) begin
            n_fail++;
            $display("FAIL overflow_count: got %0d writes need 4", wr_cnt - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (wr_addr[base+k] !== 4'(4 * k) ||
                    wr_data[base+k] !== {8'(16*k+3), 8'(16*k+2), 8'(16*k+1), 8'(16*k)}) begin
                    n_fail++;
                    $display("FAIL overflow_w%0d: got %h@%h", k, wr_data[base+k], wr_addr[base+k]);
                end
            end
        end
        pulse_start();
        check_status("restart_from_error", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base;
        base = wr_cnt;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'hB7);
        check_status("csum_match", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        n_cmp++;
        if (wr_cnt - base !== 1 || wr_data[base] !== 32'h00A00513 || wr_addr[base] !== 4'h0) begin
            n_fail++;
            $display("FAIL csum_write: got %0d writes first %h@%h", wr_cnt - base,
                     wr_data[base], wr_addr[base]);
        end
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'hB6);
        check_status("csum_mismatch", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start();
        check_status("csum_restart", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        load_start = 1'b0;
        test_reset();
        test_two_word();
        test_restart_from_done();
        test_empty();
        pulse_start();
        test_gaps();
        pulse_start();
        test_overflow();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
